// File: rtl/wide_addsubcmp_pkg.sv
// -----------------------------------------------------------------------------
// wide_addsubcmp_pkg
//
// Purpose : Shared types and helpers for the word-serial wide adder/subtractor.
//           Holds the control state encoding, the whole-operation flag bundle
//           and a couple of small helpers used by the top level.
//
// Contents:
//   state_t      - IDLE / RUN / DRAIN control states
//   flags_t      - carry, zero, sign, overflow of a finished operation
//   FLAGS_CLEAR  - all-zero flag value used at reset and at operation start
//   carry_seed() - carry-in for the least significant word
// -----------------------------------------------------------------------------
package wide_addsubcmp_pkg;

    // IDLE  : waiting for Start_i, nothing in flight
    // RUN   : accepting operand words, one per handshake
    // DRAIN : last operand word consumed, waiting for its result to leave
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Flags describe the complete multi-word result, not any single word.
    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
        logic overflow;
    } flags_t;

    localparam flags_t FLAGS_CLEAR = '{carry: 1'b0, zero: 1'b0, sign: 1'b0, overflow: 1'b0};

    // A subtraction is done as A + ~B + 1, so the external borrow input is
    // folded into the first carry-in by inversion: borrow 0 means carry 1.
    function automatic logic carry_seed(input logic sub, input logic carry_in);
        return sub ? ~carry_in : carry_in;
    endfunction

    // Counter width that stays legal for a single-word configuration.
    function automatic int count_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage : wide_addsubcmp_pkg

// File: rtl/wide_addsubcmp_addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
//
// Purpose : Purely combinational Width-bit adder/subtractor slice. The top level
//           reuses one instance for every word of a wide operation, feeding the
//           carry of the previous word back in through a register.
//
// Parameters:
//   Width     - bits per slice (>= 2)
//
// Ports:
//   a, b      - operand words
//   sub       - 1 = compute a + ~b + carry_in, 0 = a + b + carry_in
//   carry_in  - incoming carry for this word
//   sum       - Width-bit result word
//   carry_out - raw carry out of the slice (not inverted for subtraction)
//   sign      - MSB of the result word
//   overflow  - signed overflow of this slice treated as the top word
// -----------------------------------------------------------------------------
module addsub_slice #(
    parameter int Width = 16
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
    output logic [Width-1:0] sum,
    output logic             carry_out,
    output logic             sign,
    output logic             overflow
);

    logic [Width-1:0] b_eff;
    logic [Width:0]   total;

    // The B operand is inverted for subtraction; the +1 of two's complement
    // arrives through carry_in, which the top level seeds accordingly.
    // One extra bit on the sum captures the raw carry out.
    always_comb begin
        b_eff = sub ? ~b : b;
        total = {1'b0, a} + {1'b0, b_eff} + {{Width{1'b0}}, carry_in};
    end

    assign sum       = total[Width-1:0];
    assign carry_out = total[Width];
    assign sign      = total[Width-1];

    // Signed overflow: both effective operands share a sign but the result
    // came out with the other sign.
    assign overflow  = (a[Width-1] == b_eff[Width-1]) && (total[Width-1] != a[Width-1]);

endmodule : addsub_slice

// File: rtl/wide_addsubcmp.sv
// -----------------------------------------------------------------------------
// wide_addsubcmp
//
// Purpose : Word-serial wide adder/subtractor. An operation of Words words of
//           Width bits each is started with Start_i, the operand words are then
//           streamed in LSW first over a valid/ready handshake, and each result
//           word leaves one cycle later over a second valid/ready handshake.
//           Whole-operation flags (carry, zero, sign, overflow) are produced
//           together with the last result word and held until the next start.
//
// Optional feature:
//   WIDE_ADDSUBCMP_CMP_EN - when defined, adds comparison outputs LessU_o,
//                           LessS_o and Equal_o derived from the flags of the
//                           final subtraction. When undefined these ports and
//                           their logic do not exist.
//
// Parameters:
//   Width  - bits per operand word (>= 2)
//   Words  - words per operation (>= 1), least significant word first
//
// Ports:
//   Clk_i       - clock, rising edge
//   Reset_i     - asynchronous active-high reset
//   Start_i     - begin an operation (only looked at in IDLE)
//   AddOrSub_i  - 0 = A + B, 1 = A - B (captured with Start_i)
//   Carry_i     - initial carry / borrow (captured with Start_i)
//   A_i, B_i    - current operand words
//   InValid_i   - operand word valid
//   InReady_o   - operand word can be accepted
//   D_o         - result word
//   OutValid_o  - result word valid
//   OutReady_i  - downstream accepts the result word
//   Done_o      - current result word is the last of the operation
//   Carry_o     - raw carry out of the last word
//   Zero_o      - every result word of the operation was zero
//   Sign_o      - MSB of the last result word
//   Overflow_o  - signed overflow of the whole operation
//   Busy_o      - high in RUN and DRAIN
//   LessU_o, LessS_o, Equal_o - comparison results (WIDE_ADDSUBCMP_CMP_EN only)
// -----------------------------------------------------------------------------
module wide_addsubcmp
    import wide_addsubcmp_pkg::*;
#(
    parameter int Width = 16,
    parameter int Words = 4
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             Start_i,
    input  logic             AddOrSub_i,
    input  logic             Carry_i,
    input  logic [Width-1:0] A_i,
    input  logic [Width-1:0] B_i,
    input  logic             InValid_i,
    output logic             InReady_o,
    output logic [Width-1:0] D_o,
    output logic             OutValid_o,
    input  logic             OutReady_i,
    output logic             Done_o,
    output logic             Carry_o,
    output logic             Zero_o,
    output logic             Sign_o,
    output logic             Overflow_o,
    output logic             Busy_o
`ifdef WIDE_ADDSUBCMP_CMP_EN
    ,
    output logic             LessU_o,
    output logic             LessS_o,
    output logic             Equal_o
`endif
);

    localparam int             CntW    = count_width(Words);
    localparam logic [CntW-1:0] LastIdx = CntW'(Words - 1);

    state_t            state;
    logic [CntW-1:0]   word_cnt;
    logic              op_sub;
    logic              chain_carry;
    logic              zero_acc;
    flags_t            flags;
    flags_t            flags_next;

    logic [Width-1:0]  slice_sum;
    logic              slice_cout;
    logic              slice_sign;
    logic              slice_ovf;

    logic              last_word;
    logic              in_fire;
    logic              out_fire;
    logic              start_fire;
    logic              sum_is_zero;

    // A new operand word may only enter while running, and only if the
    // output register is empty or is being emptied in this same cycle,
    // which gives full throughput without ever overwriting a held result.
    assign InReady_o   = (state == ST_RUN) && (!OutValid_o || OutReady_i);
    assign in_fire     = InValid_i && InReady_o;
    assign out_fire    = OutValid_o && OutReady_i;
    assign start_fire  = (state == ST_IDLE) && Start_i;
    assign last_word   = (word_cnt == LastIdx);
    assign sum_is_zero = (slice_sum == '0);
    assign Busy_o      = (state != ST_IDLE);

    // One shared slice handles every word; the carry between words lives in
    // chain_carry so that word k sees the raw carry out of word k-1.
    addsub_slice #(
        .Width     (Width)
    ) u_slice (
        .a         (A_i),
        .b         (B_i),
        .sub       (op_sub),
        .carry_in  (chain_carry),
        .sum       (slice_sum),
        .carry_out (slice_cout),
        .sign      (slice_sign),
        .overflow  (slice_ovf)
    );

    // Control state, word counter and the per-operation context captured at
    // start. The counter stops at the last index rather than wrapping, since
    // the state leaves RUN at that point anyway.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state       <= ST_IDLE;
            word_cnt    <= '0;
            op_sub      <= 1'b0;
            chain_carry <= 1'b0;
            zero_acc    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start_i) begin
                        state       <= ST_RUN;
                        word_cnt    <= '0;
                        op_sub      <= AddOrSub_i;
                        chain_carry <= carry_seed(AddOrSub_i, Carry_i);
                        zero_acc    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (in_fire) begin
                        chain_carry <= slice_cout;
                        zero_acc    <= zero_acc & sum_is_zero;
                        if (last_word) begin
                            state <= ST_DRAIN;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_fire && Done_o) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result register. A newly accepted word always wins over the downstream
    // taking the old one, which is what keeps a word flowing every cycle;
    // when stalled, nothing here changes so D_o and OutValid_o hold.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            D_o        <= '0;
            OutValid_o <= 1'b0;
            Done_o     <= 1'b0;
        end else if (in_fire) begin
            D_o        <= slice_sum;
            OutValid_o <= 1'b1;
            Done_o     <= last_word;
        end else if (out_fire) begin
            OutValid_o <= 1'b0;
            Done_o     <= 1'b0;
        end
    end

    // Flags of the finished operation, formed from the last slice result and
    // the zero status accumulated over the earlier words.
    always_comb begin
        flags_next          = flags;
        flags_next.carry    = slice_cout;
        flags_next.zero     = zero_acc & sum_is_zero;
        flags_next.sign     = slice_sign;
        flags_next.overflow = slice_ovf;
    end

    // Flags are cleared when an operation starts so that stale values from a
    // previous run never appear alongside a new result, and they are loaded
    // on the same edge that registers the last result word.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            flags <= FLAGS_CLEAR;
        end else if (start_fire) begin
            flags <= FLAGS_CLEAR;
        end else if (in_fire && last_word) begin
            flags <= flags_next;
        end
    end

    assign Carry_o    = flags.carry;
    assign Zero_o     = flags.zero;
    assign Sign_o     = flags.sign;
    assign Overflow_o = flags.overflow;

`ifdef WIDE_ADDSUBCMP_CMP_EN
    // Comparison view of a finished A - B: no borrow means A >= B unsigned,
    // and the true sign of the signed difference is sign xor overflow.
    assign Equal_o = flags.zero;
    assign LessU_o = ~flags.carry;
    assign LessS_o = flags.sign ^ flags.overflow;
`endif

endmodule : wide_addsubcmp

// File: tb/tb_wide_addsubcmp.sv
// -----------------------------------------------------------------------------
// tb_wide_addsubcmp
//
// Self-checking bench for wide_addsubcmp (Width=16, Words=4). A fixed table of
// directed operations with hand-derived results is applied first, followed by
// hand-written sequences for output back-pressure, an ignored start pulse and
// a mid-operation reset, and finally randomized operations whose results come
// from a plain wide-integer reference model. Comparison outputs are checked
// when WIDE_ADDSUBCMP_CMP_EN is defined.
// -----------------------------------------------------------------------------
module tb_wide_addsubcmp;

    localparam int W  = 16;
    localparam int WD = 4;
    localparam int N  = W * WD;

    logic          Clk_i;
    logic          Reset_i;
    logic          Start_i;
    logic          AddOrSub_i;
    logic          Carry_i;
    logic [W-1:0]  A_i;
    logic [W-1:0]  B_i;
    logic          InValid_i;
    logic          InReady_o;
    logic [W-1:0]  D_o;
    logic          OutValid_o;
    logic          OutReady_i;
    logic          Done_o;
    logic          Carry_o;
    logic          Zero_o;
    logic          Sign_o;
    logic          Overflow_o;
    logic          Busy_o;
`ifdef WIDE_ADDSUBCMP_CMP_EN
    logic          LessU_o;
    logic          LessS_o;
    logic          Equal_o;
`endif

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        bit           sub;
        bit           cin;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] d;
        bit           c;
        bit           z;
        bit           s;
        bit           v;
    } vec_t;

    vec_t vecs [8];

    wide_addsubcmp #(
        .Width      (W),
        .Words      (WD)
    ) dut (
        .Clk_i      (Clk_i),
        .Reset_i    (Reset_i),
        .Start_i    (Start_i),
        .AddOrSub_i (AddOrSub_i),
        .Carry_i    (Carry_i),
        .A_i        (A_i),
        .B_i        (B_i),
        .InValid_i  (InValid_i),
        .InReady_o  (InReady_o),
        .D_o        (D_o),
        .OutValid_o (OutValid_o),
        .OutReady_i (OutReady_i),
        .Done_o     (Done_o),
        .Carry_o    (Carry_o),
        .Zero_o     (Zero_o),
        .Sign_o     (Sign_o),
        .Overflow_o (Overflow_o),
        .Busy_o     (Busy_o)
`ifdef WIDE_ADDSUBCMP_CMP_EN
        ,
        .LessU_o    (LessU_o),
        .LessS_o    (LessS_o),
        .Equal_o    (Equal_o)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        Clk_i = 1'b0;
        forever #5 Clk_i = ~Clk_i;
    end

    task automatic checkOutput(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference model: the whole operation as one wide integer sum or
    // difference, with signed overflow judged on a one-bit-wider signed value.
    task automatic refModel(input bit sub, input bit cin, input logic [N-1:0] a, input logic [N-1:0] b,
                            output logic [N-1:0] d, output bit c, output bit z, output bit s, output bit v);
        logic [N:0]        u;
        logic signed [N:0] r;
        if (!sub) begin
            u = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
            c = u[N];
            r = $signed({a[N-1], a}) + $signed({b[N-1], b}) + $signed((N+1)'(cin));
        end else begin
            u = {1'b0, a} - {1'b0, b} - (N+1)'(cin);
            c = ~u[N];
            r = $signed({a[N-1], a}) - $signed({b[N-1], b}) - $signed((N+1)'(cin));
        end
        d = u[N-1:0];
        z = (d == '0);
        s = d[N-1];
        v = (r[N] != r[N-1]);
    endtask

    // Runs one complete operation. stallMask bit k drops OutReady_i in loop
    // cycle k; startGlitch holds Start_i high during the whole operation.
    task automatic applyStimulus(input string tag, input bit sub, input bit cin,
                                 input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [N-1:0] expD, input bit ec, input bit ez,
                                 input bit es, input bit ev,
                                 input logic [31:0] stallMask, input bit startGlitch);
        logic [W-1:0] got [WD];
        logic [W-1:0] heldD;
        bit           holding;
        bit           inFire;
        int           inIdx;
        int           outIdx;
        int           cyc;
        int           sel;
        for (int k = 0; k < WD; k++) got[k] = '0;
        holding = 0;
        heldD   = '0;
        inIdx   = 0;
        outIdx  = 0;
        cyc     = 0;

        @(negedge Clk_i);
        Start_i    = 1'b1;
        AddOrSub_i = sub;
        Carry_i    = cin;
        InValid_i  = 1'b1;
        A_i        = 16'hDEAD;
        B_i        = 16'hBEEF;
        OutReady_i = 1'b1;
        @(negedge Clk_i);
        Start_i    = startGlitch;
        AddOrSub_i = ~sub;
        Carry_i    = ~cin;

        while (outIdx < WD && cyc < 200) begin
            sel        = (inIdx < WD) ? inIdx : 0;
            OutReady_i = ~stallMask[cyc % 32];
            InValid_i  = (inIdx < WD);
            A_i        = a[sel*W +: W];
            B_i        = b[sel*W +: W];
            #1;
            if (cyc == 0) checkOutput({tag, " busy"}, N'(Busy_o), N'(1));
            if (holding) begin
                checkOutput({tag, " stall D hold"}, N'(D_o), N'(heldD));
                checkOutput({tag, " stall valid hold"}, N'(OutValid_o), N'(1));
            end
            if (OutValid_o && !OutReady_i) begin
                checkOutput({tag, " stall InReady"}, N'(InReady_o), N'(0));
                holding = 1;
                heldD   = D_o;
            end else begin
                holding = 0;
            end
            inFire = InValid_i && InReady_o;
            if (OutValid_o && OutReady_i) begin
                got[outIdx] = D_o;
                checkOutput($sformatf("%s done w%0d", tag, outIdx), N'(Done_o), N'(outIdx == WD - 1));
                outIdx++;
            end
            if (inFire) inIdx++;
            cyc++;
            @(negedge Clk_i);
        end
        Start_i   = 1'b0;
        InValid_i = 1'b0;

        checkOutput({tag, " words delivered"}, N'(outIdx), N'(WD));
        checkOutput({tag, " words consumed"}, N'(inIdx), N'(WD));
        if (stallMask == 32'h0) checkOutput({tag, " cycles"}, N'(cyc), N'(WD + 1));
        for (int k = 0; k < WD; k++) begin
            checkOutput($sformatf("%s D w%0d", tag, k), N'(got[k]), N'(expD[k*W +: W]));
        end
        #1;
        checkOutput({tag, " idle busy"}, N'(Busy_o), N'(0));
        checkOutput({tag, " idle valid"}, N'(OutValid_o), N'(0));
        checkOutput({tag, " idle inready"}, N'(InReady_o), N'(0));
        checkOutput({tag, " Carry_o"}, N'(Carry_o), N'(ec));
        checkOutput({tag, " Zero_o"}, N'(Zero_o), N'(ez));
        checkOutput({tag, " Sign_o"}, N'(Sign_o), N'(es));
        checkOutput({tag, " Overflow_o"}, N'(Overflow_o), N'(ev));
`ifdef WIDE_ADDSUBCMP_CMP_EN
        if (sub && !cin) begin
            checkOutput({tag, " Equal_o"}, N'(Equal_o), N'(a == b));
            checkOutput({tag, " LessU_o"}, N'(LessU_o), N'(a < b));
            checkOutput({tag, " LessS_o"}, N'($signed(a) < $signed(b)), N'(LessS_o));
        end
`endif
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [N-1:0] rd;
        bit           rsub;
        bit           rcin;
        bit           rc;
        bit           rz;
        bit           rs;
        bit           rv;
        logic [31:0]  rmask;

        // Directed operations with hand-derived results.
        vecs[0] = '{0, 0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0001_0000, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0000, 1, 1, 0, 0};
        vecs[2] = '{0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 0, 0, 1, 1};
        vecs[3] = '{1, 0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0};
        vecs[4] = '{0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1, 1, 0, 0};
        vecs[5] = '{0, 1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 0, 0, 0, 0};
        vecs[6] = '{1, 0, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0, 1};
        vecs[7] = '{1, 1, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0001, 1, 0, 0, 0};

        Reset_i    = 1'b1;
        Start_i    = 1'b0;
        AddOrSub_i = 1'b0;
        Carry_i    = 1'b0;
        A_i        = '0;
        B_i        = '0;
        InValid_i  = 1'b0;
        OutReady_i = 1'b1;
        #1;
        $display("[TB] checking reset state");
        checkOutput("reset D_o", N'(D_o), N'(0));
        checkOutput("reset OutValid_o", N'(OutValid_o), N'(0));
        checkOutput("reset Done_o", N'(Done_o), N'(0));
        checkOutput("reset Busy_o", N'(Busy_o), N'(0));
        checkOutput("reset InReady_o", N'(InReady_o), N'(0));
        checkOutput("reset flags", N'({Carry_o, Zero_o, Sign_o, Overflow_o}), N'(0));
        repeat (2) @(negedge Clk_i);
        Reset_i = 1'b0;

        $display("[TB] directed table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b,
                          vecs[i].d, vecs[i].c, vecs[i].z, vecs[i].s, vecs[i].v, 32'h0, 1'b0);
        end

        $display("[TB] back-pressure for three cycles mid-operation");
        applyStimulus("stall", 1'b0, 1'b0, 64'h0001_FFFF_0002_FFFF, 64'h0000_0001_0000_0001,
                      64'h0002_0000_0003_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_001C, 1'b0);

        $display("[TB] start held high while running");
        applyStimulus("glitch", 1'b1, 1'b0, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0005,
                      64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        $display("[TB] reset after two accepted words");
        @(negedge Clk_i);
        Start_i    = 1'b1;
        AddOrSub_i = 1'b0;
        Carry_i    = 1'b0;
        InValid_i  = 1'b0;
        @(negedge Clk_i);
        Start_i    = 1'b0;
        InValid_i  = 1'b1;
        OutReady_i = 1'b1;
        A_i        = 16'h2222;
        B_i        = 16'h0001;
        @(negedge Clk_i);
        A_i        = 16'h1111;
        B_i        = 16'h0000;
        @(negedge Clk_i);
        #1;
        checkOutput("pre-reset D_o", N'(D_o), N'(16'h1111));
        #1;
        Reset_i = 1'b1;
        #1;
        checkOutput("async reset D_o", N'(D_o), N'(0));
        checkOutput("async reset OutValid_o", N'(OutValid_o), N'(0));
        checkOutput("async reset Done_o", N'(Done_o), N'(0));
        checkOutput("async reset Busy_o", N'(Busy_o), N'(0));
        checkOutput("async reset InReady_o", N'(InReady_o), N'(0));
        checkOutput("async reset flags", N'({Carry_o, Zero_o, Sign_o, Overflow_o}), N'(0));
        @(negedge Clk_i);
        Reset_i   = 1'b0;
        InValid_i = 1'b0;
        applyStimulus("post-reset", 1'b1, 1'b0, 64'hAAAA_5555_0000_0001, 64'hAAAA_5555_0000_0001,
                      64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("[TB] randomized operations against reference model");
        for (int i = 0; i < 24; i++) begin
            ra    = {$urandom, $urandom};
            rb    = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
            rsub  = 1'($urandom_range(0, 1));
            rcin  = 1'($urandom_range(0, 1));
            rmask = ($urandom_range(0, 1) == 0) ? 32'h0 : ($urandom & $urandom);
            refModel(rsub, rcin, ra, rb, rd, rc, rz, rs, rv);
            applyStimulus($sformatf("rand%0d", i), rsub, rcin, ra, rb, rd, rc, rz, rs, rv, rmask, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule : tb_wide_addsubcmp
